// File: rtl/rst_seq.sv
// Reset sequencer: merges the external reset with maskable soft-reset
// requests, stretches the result and releases n_out resets in order.
//
// Ports:
//   clk            system clock
//   c_ex_rst       external reset, async assert, active high
//   c_user_rst     soft-reset requests (level or pulse), one per source
//   c_src_mask     per-source enable, 1 = enabled
//   c_cause_clr    synchronous clear of rst_cause
//   sys_rst        sequenced active-high resets, bit 0 released first
//   c_sys_rst_done high once every sys_rst bit is released
//   rst_cause      bit 0 = external, bit k+1 = soft source k
//   rst_cnt        saturating count of soft-reset events
module rst_seq #(
    parameter int n_src       = 2,
    parameter int n_out       = 3,
    parameter int stretch_cyc = 16,
    parameter int stagger_cyc = 4,
    parameter int cnt_bw      = 8
) (
    input  logic              clk,
    input  logic              c_ex_rst,
    input  logic [n_src-1:0]  c_user_rst,
    input  logic [n_src-1:0]  c_src_mask,
    input  logic              c_cause_clr,
    output logic [n_out-1:0]  sys_rst,
    output logic              c_sys_rst_done,
    output logic [n_src:0]    rst_cause,
    output logic [cnt_bw-1:0] rst_cnt
);

    localparam int cmax = (stretch_cyc > stagger_cyc) ? stretch_cyc
                                                      : stagger_cyc;
    localparam int cw = $clog2(cmax + 1);
    localparam int iw = $clog2(n_out + 1);

    localparam logic [cw-1:0]     str_last = cw'(stretch_cyc - 1);
    localparam logic [cw-1:0]     stg_last = cw'(stagger_cyc - 1);
    localparam logic [iw-1:0]     idx_last = iw'(n_out - 1);
    localparam logic [cnt_bw-1:0] cnt_max  = '1;

    typedef enum logic [1:0] {
        ASSERT,
        RELEASE,
        RUN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [cw-1:0]     cnt;
    logic [cw-1:0]     cnt_nx;
    logic [iw-1:0]     idx;
    logic [iw-1:0]     idx_nx;
    logic [n_out-1:0]  sys_rst_nx;
    logic              done_nx;
    logic [n_src:0]    cause_nx;
    logic [n_src:0]    cause_base;
    logic [cnt_bw-1:0] rst_cnt_nx;
    logic [cnt_bw-1:0] rst_cnt_inc;

    logic [n_src-1:0]  hit;
    logic              req;

    assign hit = c_user_rst & c_src_mask;
    assign req = |hit;

    // A clear and a simultaneous request both act: the clear wipes
    // the old cause, the request's bits land on top of it.
    assign cause_base  = c_cause_clr ? '0 : rst_cause;
    assign rst_cnt_inc = (rst_cnt == cnt_max) ? rst_cnt
                                              : rst_cnt + cnt_bw'(1);

    always_ff @(posedge clk or posedge c_ex_rst) begin
        if (c_ex_rst) begin
            state          <= ASSERT;
            cnt            <= '0;
            idx            <= '0;
            sys_rst        <= '1;
            c_sys_rst_done <= 1'b0;
            rst_cause      <= (n_src + 1)'(1);
            rst_cnt        <= '0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            idx            <= idx_nx;
            sys_rst        <= sys_rst_nx;
            c_sys_rst_done <= done_nx;
            rst_cause      <= cause_nx;
            rst_cnt        <= rst_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        idx_nx     = idx;
        sys_rst_nx = sys_rst;
        done_nx    = c_sys_rst_done;
        cause_nx   = cause_base;
        rst_cnt_nx = rst_cnt;

        unique case (state)
            ASSERT: begin
                sys_rst_nx = '1;
                done_nx    = 1'b0;
                if (req) begin
                    // Restart the stretch; a held request counts once.
                    cnt_nx   = '0;
                    cause_nx = cause_base | {hit, 1'b0};
                end else if (cnt == str_last) begin
                    cnt_nx        = '0;
                    idx_nx        = iw'(1);
                    sys_rst_nx[0] = 1'b0;
                    if (n_out == 1) begin
                        state_nx = RUN;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = RELEASE;
                    end
                end else begin
                    cnt_nx = cnt + cw'(1);
                end
            end

            RELEASE: begin
                if (req) begin
                    state_nx   = ASSERT;
                    cnt_nx     = '0;
                    idx_nx     = '0;
                    sys_rst_nx = '1;
                    done_nx    = 1'b0;
                    cause_nx   = cause_base | {hit, 1'b0};
                    rst_cnt_nx = rst_cnt_inc;
                end else if (cnt == stg_last) begin
                    cnt_nx = '0;
                    for (int i = 0; i < n_out; i++) begin
                        if (iw'(i) == idx) begin
                            sys_rst_nx[i] = 1'b0;
                        end
                    end
                    if (idx == idx_last) begin
                        state_nx = RUN;
                        done_nx  = 1'b1;
                    end else begin
                        idx_nx = idx + iw'(1);
                    end
                end else begin
                    cnt_nx = cnt + cw'(1);
                end
            end

            RUN: begin
                if (req) begin
                    state_nx   = ASSERT;
                    cnt_nx     = '0;
                    idx_nx     = '0;
                    sys_rst_nx = '1;
                    done_nx    = 1'b0;
                    cause_nx   = {hit, 1'b0};
                    rst_cnt_nx = rst_cnt_inc;
                end
            end

            default: begin
                state_nx   = ASSERT;
                cnt_nx     = '0;
                idx_nx     = '0;
                sys_rst_nx = '1;
                done_nx    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rst_seq.sv
// Testbench for rst_seq: directed scenarios plus random requests,
// compared every cycle against an edge-count reference model.
module tb_rst_seq;

    localparam int NS  = 2;
    localparam int NO  = 3;
    localparam int STR = 16;
    localparam int STG = 4;

    logic          clk = 1'b0;
    logic          c_ex_rst = 1'b1;
    logic [NS-1:0] c_user_rst = '0;
    logic [NS-1:0] c_src_mask = '1;
    logic          c_cause_clr = 1'b0;

    logic [NO-1:0] sys_rst;
    logic          c_sys_rst_done;
    logic [NS:0]   rst_cause;
    logic [7:0]    rst_cnt;

    logic [NO-1:0] sys_rst2;
    logic          done2;
    logic [NS:0]   cause2;
    logic [1:0]    rst_cnt2;

    int pass_cnt = 0;
    int total    = 0;

    // Model: last reset event edge and the edge count since c_ex_rst fell.
    int          n = 0;
    int          last_evt = 0;
    logic [NS:0] m_cause = 3'b001;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    rst_seq dut (
        .clk            (clk),
        .c_ex_rst       (c_ex_rst),
        .c_user_rst     (c_user_rst),
        .c_src_mask     (c_src_mask),
        .c_cause_clr    (c_cause_clr),
        .sys_rst        (sys_rst),
        .c_sys_rst_done (c_sys_rst_done),
        .rst_cause      (rst_cause),
        .rst_cnt        (rst_cnt)
    );

    rst_seq #(.cnt_bw(2)) dut_sat (
        .clk            (clk),
        .c_ex_rst       (c_ex_rst),
        .c_user_rst     (c_user_rst),
        .c_src_mask     (c_src_mask),
        .c_cause_clr    (c_cause_clr),
        .sys_rst        (sys_rst2),
        .c_sys_rst_done (done2),
        .rst_cause      (cause2),
        .rst_cnt        (rst_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s edge=%0d observed=%0h expected=%0h",
                    tag, n, obs, exp);
    endtask

    function automatic logic [NO-1:0] exp_rst();
        logic [NO-1:0] r;
        for (int k = 0; k < NO; k++)
            r[k] = (n < last_evt + STR + k * STG);
        return r;
    endfunction

    function automatic logic exp_done();
        return n >= last_evt + STR + (NO - 1) * STG;
    endfunction

    task automatic check_all();
        check("sys_rst", 32'(sys_rst), 32'(exp_rst()));
        check("done", 32'(c_sys_rst_done), 32'(exp_done()));
        check("cause", 32'(rst_cause), 32'(m_cause));
        check("cnt", 32'(rst_cnt), (m_cnt > 255) ? 255 : m_cnt);
        check("sat_rst", 32'(sys_rst2), 32'(exp_rst()));
        check("sat_cnt", 32'(rst_cnt2), (m_cnt > 3) ? 3 : m_cnt);
    endtask

    // Called at a falling edge; applies inputs for the next rising edge.
    task automatic step(input logic [NS-1:0] u, input logic [NS-1:0] m,
                        input logic clr);
        logic [NS-1:0] bits;
        logic [NS:0]   base;
        c_user_rst  = u;
        c_src_mask  = m;
        c_cause_clr = clr;
        @(posedge clk);
        bits = u & m;
        base = clr ? '0 : m_cause;
        if (|bits) begin
            if (n < last_evt + STR) begin
                m_cause = base | {bits, 1'b0};
            end else if (n >= last_evt + STR + (NO - 1) * STG) begin
                m_cause = {bits, 1'b0};
                m_cnt++;
            end else begin
                m_cause = base | {bits, 1'b0};
                m_cnt++;
            end
            last_evt = n + 1;
        end else begin
            m_cause = base;
        end
        n++;
        @(negedge clk);
        check_all();
    endtask

    task automatic do_ex_reset();
        #2;
        c_ex_rst = 1'b1;
        n        = 0;
        last_evt = 0;
        m_cause  = 3'b001;
        m_cnt    = 0;
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        c_user_rst  = '0;
        c_cause_clr = 1'b0;
        c_ex_rst    = 1'b0;
    endtask

    initial begin
        logic [NS-1:0] u;
        logic [NS-1:0] m;
        logic          clr;

        @(negedge clk);
        do_ex_reset();
        repeat (30) step(2'b00, 2'b11, 1'b0);

        step(2'b10, 2'b11, 1'b0);
        repeat (30) step(2'b00, 2'b11, 1'b0);

        repeat (50) step(2'b10, 2'b01, 1'b0);

        step(2'b10, 2'b11, 1'b0);
        repeat (17) step(2'b00, 2'b11, 1'b0);
        step(2'b01, 2'b11, 1'b0);
        repeat (10) step(2'b00, 2'b11, 1'b0);
        repeat (6) step(2'b01, 2'b11, 1'b0);
        repeat (30) step(2'b00, 2'b11, 1'b0);

        step(2'b10, 2'b11, 1'b0);
        repeat (18) step(2'b00, 2'b11, 1'b0);
        do_ex_reset();
        repeat (30) step(2'b00, 2'b11, 1'b0);

        repeat (5) begin
            step(2'b01, 2'b11, 1'b0);
            repeat (26) step(2'b00, 2'b11, 1'b0);
        end
        check("sat_value", 32'(rst_cnt2), 32'd3);
        step(2'b00, 2'b11, 1'b1);
        check("clr_only", 32'(rst_cause), 32'b000);
        step(2'b01, 2'b11, 1'b1);
        check("clr_and_req", 32'(rst_cause), 32'b010);
        repeat (30) step(2'b00, 2'b11, 1'b0);

        for (int i = 0; i < 600; i++) begin
            if (i % 200 == 199) do_ex_reset();
            u   = ($urandom_range(0, 11) == 0) ? NS'($urandom) : '0;
            m   = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '1;
            clr = ($urandom_range(0, 19) == 0);
            step(u, m, clr);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
